demux2: RTL and testbench
=========================

Name: demux2

Overview:
- Clocked four-phase bundled-data demultiplexer: one input channel (r_i/a_i/d_i) is steered to output 0 or output 1.
- The steering decision comes from a control channel (rctl_i/dctl_i/actl_i).
- It is the splitting counterpart of the two-input merge mux: used where a stream fans out by a data-dependent select and is later recombined.
- One token in, one token out; data is registered once per handshake.

Parameters:
- N, 1, data width in bits of d_i, d0_o and d1_o.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- r_i  input  1  input-channel request (four-phase).
- a_i  output  1  input-channel acknowledge.
- d_i  input  N  input data, valid while r_i is high.
- rctl_i  input  1  control-channel request.
- dctl_i  input  1  select: 0 routes to output 0, 1 routes to output 1.
- actl_i  output  1  control-channel acknowledge.
- r0_o  output  1  output-0 request.
- a0_o  input  1  output-0 acknowledge.
- d0_o  output  N  output-0 data.
- r1_o  output  1  output-1 request.
- a1_o  input  1  output-1 acknowledge.
- d1_o  output  N  output-1 data.

Behaviour:
- Protocol is four-phase return-to-zero on every channel: req↑, ack↑, req↓, ack↓. Data must be stable from req↑ until ack↑.
- Reset (rst=1, asynchronous): state=IDLE; a_i, actl_i, r0_o, r1_o = 0; data register = 0; sel register = 0.
- d0_o and d1_o are both driven from the single data register. Only the selected r*_o qualifies them.
- Let ax = a0_o when sel=0, a1_o when sel=1. Let rx_o be the selected request.
- IDLE:
  - If r_i=1 and rctl_i=1 at an edge: capture d_i→data register and dctl_i→sel.
  - Assert the selected rx_o (registered, visible one cycle after that edge). Go to REQ.
  - If only one of r_i/rctl_i is high, wait. No acknowledge is issued on a lone channel.
- REQ: wait for ax=1. Then deassert rx_o, assert a_i and actl_i in the same edge, and go to ACK.
- ACK:
  - Wait until r_i=0, rctl_i=0 and ax=0 all hold at one edge.
  - Then deassert a_i and actl_i and go to IDLE.
  - These conditions may arrive in any order or simultaneously.
- Latency, best case: r_i/rctl_i↑ edge n → rx_o↑ after edge n. ax↑ seen at edge m → a_i/actl_i↑ after edge m.
- Minimum cycle: 3 clocks per token when the environment responds within one cycle.
- The unselected request stays 0 throughout. An ack on the unselected output is ignored.
- dctl_i and d_i are sampled only on the IDLE→REQ edge. Later changes are ignored.
- The data register holds from capture until the next capture, so output data stays stable through rx_o↓.
- State encoding: IDLE=2'b00, REQ=2'b01, ACK=2'b10. 2'b11 is illegal and recovers to IDLE with all outputs 0.
- Reset mid-handshake forces IDLE and all outputs 0 immediately. The environment is responsible for returning to zero.

Optional Feature:
- Macro: DEMUX2_INSYNC_EN.
- Defined: r_i, rctl_i, a0_o and a1_o each pass through a two-flop synchronizer before the FSM. This adds 2 cycles to each wait. Synchronizer flops reset to 0. d_i and dctl_i are not synchronized; they remain bundled-data timed.
- Undefined: inputs feed the FSM directly and the latencies above apply exactly.

Decomposition:
- Shared package: state encoding constants (IDLE/REQ/ACK) and the four-phase phase names used by the other handshake blocks.
- One sub-module: sync2, a parameterless 1-bit two-flop synchronizer with clk/rst. It is instantiated four times only under DEMUX2_INSYNC_EN.

Test Plan:
- Route to 0: N=8, d_i=8'hA5, dctl_i=0, raise r_i and rctl_i → r0_o=1 next cycle, d0_o=8'hA5, r1_o stays 0. a0_o↑ → a_i=actl_i=1, r0_o=0.
- Route to 1, then full return-to-zero: dctl_i=1, d_i=8'h3C → r1_o=1, d1_o=8'h3C. Drop r_i, rctl_i and a1_o → a_i=actl_i=0 and state=IDLE.
- Lone channel: r_i=1, rctl_i=0 for 10 cycles → no outputs change. Raise rctl_i → r*_o asserts the next cycle.
- Out-of-order release: in ACK, drop r_i, hold rctl_i=1 for 5 cycles → a_i and actl_i stay 1. Drop rctl_i → both fall the next cycle.
- Wrong-side ack: sel=0 and a1_o pulses in REQ → no response. Only a0_o completes the handshake.
- Async reset in REQ: assert rst mid-cycle → r0_o, a_i, actl_i = 0 before the next edge. After release, the next token routes correctly.
- With DEMUX2_INSYNC_EN: repeat route-to-0 → r0_o rises 3 cycles after r_i/rctl_i instead of 1.

Source files
------------

// File: rtl/demux2_pkg.sv
// Shared definitions for the four-phase handshake blocks: FSM state encoding
// and the names of the four protocol phases.
package demux2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10
  } state_t;

  // Four-phase return-to-zero sequence as seen on any single channel.
  typedef enum logic [1:0] {
    PH_REQ_RISE = 2'b00,
    PH_ACK_RISE = 2'b01,
    PH_REQ_FALL = 2'b10,
    PH_ACK_FALL = 2'b11
  } phase_t;

endpackage

// File: rtl/demux2_sync2.sv
// Two-flop synchronizer for a single-bit level; both flops clear on reset.
// Used by demux2 only when DEMUX2_INSYNC_EN is defined.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/demux2.sv
// Four-phase bundled-data demultiplexer: one token from the input channel is
// steered to output 0 or 1 by the control channel. Optional: DEMUX2_INSYNC_EN.
module demux2
  import demux2_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         rctl_i,
  input  logic         dctl_i,
  output logic         actl_i,
  output logic         r0_o,
  input  logic         a0_o,
  output logic [N-1:0] d0_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o
);

  logic r_s, rctl_s, a0_s, a1_s;

`ifdef DEMUX2_INSYNC_EN
  // Handshake levels only; d_i/dctl_i stay bundled with their request.
  sync2 u_sync_r    (.clk(clk), .rst(rst), .d(r_i),    .q(r_s));
  sync2 u_sync_rctl (.clk(clk), .rst(rst), .d(rctl_i), .q(rctl_s));
  sync2 u_sync_a0   (.clk(clk), .rst(rst), .d(a0_o),   .q(a0_s));
  sync2 u_sync_a1   (.clk(clk), .rst(rst), .d(a1_o),   .q(a1_s));
`else
  assign r_s    = r_i;
  assign rctl_s = rctl_i;
  assign a0_s   = a0_o;
  assign a1_s   = a1_o;
`endif

  state_t       state_q, state_d;
  logic         req_q, req_d;
  logic         ack_q, ack_d;
  logic         sel_q, sel_d;
  logic [N-1:0] data_q, data_d;
  logic         ax;

  // Acknowledge from the side the current token was routed to.
  assign ax = sel_q ? a1_s : a0_s;

  // NOTE: the data register is a plain flop bank, so it can take the reset
  // value alongside the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      sel_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        ack_d = 1'b0;
        if (r_s && rctl_s) begin
          data_d  = d_i;
          sel_d   = dctl_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ax) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!r_s && !rctl_s && !ax) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign a_i    = ack_q;
  assign actl_i = ack_q;
  assign r0_o   = req_q & ~sel_q;
  assign r1_o   = req_q &  sel_q;
  assign d0_o   = data_q;
  assign d1_o   = data_q;

endmodule

// File: tb/tb_demux2.sv
// Directed bench for demux2: stimulus pushes expected tokens into a queue, a
// monitor pops one whenever a request rises and compares route and data.
module tb_demux2;

  localparam int N = 8;
`ifdef DEMUX2_INSYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L = 1 + SYNC;

  typedef struct packed {
    logic         port;
    logic [N-1:0] data;
  } token_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r_i = 1'b0, rctl_i = 1'b0, dctl_i = 1'b0;
  logic         a0_o = 1'b0, a1_o = 1'b0;
  logic [N-1:0] d_i = '0;
  logic         a_i, actl_i, r0_o, r1_o;
  logic [N-1:0] d0_o, d1_o;

  int     vectors = 0;
  int     miscompares = 0;
  token_t exp_q[$];

  demux2 #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .r_i(r_i), .a_i(a_i), .d_i(d_i),
    .rctl_i(rctl_i), .dctl_i(dctl_i), .actl_i(actl_i),
    .r0_o(r0_o), .a0_o(a0_o), .d0_o(d0_o),
    .r1_o(r1_o), .a1_o(a1_o), .d1_o(d1_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sel, input logic [N-1:0] data);
    token_t t;
    t.port = sel;
    t.data = data;
    exp_q.push_back(t);
    d_i    = data;
    dctl_i = sel;
    r_i    = 1'b1;
    rctl_i = 1'b1;
  endtask

  // Monitor: a rising request marks one token leaving the DUT.
  logic r0_prev = 1'b0, r1_prev = 1'b0;
  always @(negedge clk) begin
    token_t t;
    if (!rst && ((r0_o && !r0_prev) || (r1_o && !r1_prev))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_token", {r1_o, r0_o}, 32'd0);
      end else begin
        t = exp_q.pop_front();
        check("token_route", {r1_o, r0_o}, t.port ? 32'd2 : 32'd1);
        check("token_data", t.port ? d1_o : d0_o, t.data);
      end
    end
    r0_prev <= r0_o;
    r1_prev <= r1_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_outputs", {a_i, actl_i, r0_o, r1_o}, 32'h0);
    check("reset_data", d0_o, 32'h0);
    #10 rst = 1'b0;
    tick(1);

    // Route to output 0.
    issue(1'b0, 8'hA5);
    tick(L);
    check("rt0_req", {r0_o, r1_o}, 32'b10);
    check("rt0_d0", d0_o, 32'hA5);
    check("rt0_no_ack", {a_i, actl_i}, 32'b00);
    a0_o = 1'b1;
    tick(L);
    check("rt0_ack", {a_i, actl_i, r0_o, r1_o}, 32'b1100);
    check("rt0_data_hold", d0_o, 32'hA5);
    r_i = 1'b0; rctl_i = 1'b0; a0_o = 1'b0;
    tick(L);
    check("rt0_rtz", {a_i, actl_i}, 32'b00);

    // Route to output 1 with simultaneous release.
    issue(1'b1, 8'h3C);
    tick(L);
    check("rt1_req", {r0_o, r1_o}, 32'b01);
    check("rt1_d1", d1_o, 32'h3C);
    a1_o = 1'b1;
    tick(L);
    check("rt1_ack", {a_i, actl_i, r0_o, r1_o}, 32'b1100);
    r_i = 1'b0; rctl_i = 1'b0; a1_o = 1'b0;
    tick(L);
    check("rt1_rtz", {a_i, actl_i, r0_o, r1_o}, 32'b0000);

    // Lone data channel: nothing may move until control arrives.
    d_i = 8'h5A; dctl_i = 1'b0; r_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("lone_idle", {a_i, actl_i, r0_o, r1_o}, 32'b0000);
    end
    exp_q.push_back('{port: 1'b0, data: 8'h5A});
    rctl_i = 1'b1;
    tick(L);
    check("lone_go", {r0_o, r1_o}, 32'b10);
    a0_o = 1'b1;
    tick(L);
    check("lone_ack", {a_i, actl_i}, 32'b11);

    // Out-of-order release: control held after data and ack drop.
    r_i = 1'b0; a0_o = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("ooo_hold", {a_i, actl_i}, 32'b11);
    end
    rctl_i = 1'b0;
    tick(L);
    check("ooo_release", {a_i, actl_i}, 32'b00);

    // Wrong-side ack, plus late changes on d_i/dctl_i, must be ignored.
    issue(1'b0, 8'hC3);
    tick(L);
    d_i = 8'hFF; dctl_i = 1'b1;
    a1_o = 1'b1;
    tick(1);
    a1_o = 1'b0;
    tick(L + 2);
    check("wrong_ack_req", {a_i, actl_i, r0_o, r1_o}, 32'b0010);
    check("wrong_ack_data", d0_o, 32'hC3);
    a0_o = 1'b1;
    tick(L);
    check("right_ack", {a_i, actl_i, r0_o}, 32'b110);
    r_i = 1'b0; rctl_i = 1'b0; a0_o = 1'b0;
    tick(L);
    check("right_rtz", {a_i, actl_i}, 32'b00);

    // Asynchronous reset while in REQ.
    issue(1'b0, 8'h11);
    tick(L);
    check("rst_pre", r0_o, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    r_i = 1'b0; rctl_i = 1'b0;
    #1;
    check("rst_async", {a_i, actl_i, r0_o, r1_o}, 32'b0000);
    check("rst_data", d0_o, 32'h0);
    tick(2);
    #3 rst = 1'b0;
    tick(1);
    issue(1'b1, 8'h7E);
    tick(L);
    check("post_rst_req", {r0_o, r1_o}, 32'b01);
    a1_o = 1'b1;
    tick(L);
    check("post_rst_ack", {a_i, actl_i}, 32'b11);
    r_i = 1'b0; rctl_i = 1'b0; a1_o = 1'b0;
    tick(L);
    check("post_rst_rtz", {a_i, actl_i}, 32'b00);

    tick(2);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
